fixed_signed_arith_unit: RTL and testbench

- Signed two's-complement fixed-point arithmetic primitive for the CORDIC datapath.
- Provides a selectable adder/subtractor (x/y/angle update) and a signed magnitude comparator (angle vs target).
- Results are available combinationally for in-stage use, and as a registered, clock-enabled copy with a valid flag for pipelining.

---
 rtl/fixed_signed_arith_unit.sv | 76 +++++++
 tb/tb_fixed_signed_arith_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fixed_signed_arith_unit.sv
// Signed Q2.20 add/sub and magnitude compare for the CORDIC datapath.
// Combinational results plus a clock-enabled registered copy with valid tag.
module fixed_signed_arith_unit #(
    parameter int INTEGER_WIDTH = 2,
    parameter int DECIMAL_WIDTH = 20,
    parameter int DATA_WIDTH    = INTEGER_WIDTH + DECIMAL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] dataa,
    input  logic [DATA_WIDTH-1:0] datab,
    input  logic                  add_sub,
    input  logic [DATA_WIDTH-1:0] cmpa,
    input  logic [DATA_WIDTH-1:0] cmpb,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow,
    output logic                  aeb,
    output logic                  agb,
    output logic [DATA_WIDTH-1:0] result_q,
    output logic                  overflow_q,
    output logic                  aeb_q,
    output logic                  agb_q,
    output logic                  valid_out
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] opb_eff;
    logic [DATA_WIDTH-1:0] cin_ext;
    logic [DATA_WIDTH-1:0] sum;

    // Subtract as A + ~B + 1 so a single adder serves both operations.
    always_comb begin
        opb_eff = add_sub ? datab : ~datab;
        cin_ext = '0;
        cin_ext[0] = ~add_sub;
        sum = dataa + opb_eff + cin_ext;
    end

    assign result   = sum;
    assign overflow = (dataa[MSB] == opb_eff[MSB]) && (sum[MSB] != dataa[MSB]);

    assign aeb = (cmpa == cmpb);
    assign agb = ($signed(cmpa) > $signed(cmpb));

    logic [DATA_WIDTH-1:0] res_q;
    logic                  ovf_q;
    logic                  eq_q;
    logic                  gt_q;
    logic                  vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            ovf_q <= 1'b0;
            eq_q  <= 1'b0;
            gt_q  <= 1'b0;
            vld_q <= 1'b0;
        end else if (clk_en) begin
            res_q <= result;
            ovf_q <= overflow;
            eq_q  <= aeb;
            gt_q  <= agb;
            vld_q <= valid_in;
        end
    end

    assign result_q   = res_q;
    assign overflow_q = ovf_q;
    assign aeb_q      = eq_q;
    assign agb_q      = gt_q;
    assign valid_out  = vld_q;

endmodule

// File: tb/tb_fixed_signed_arith_unit.sv
// Scoreboard bench for fixed_signed_arith_unit.
// Expected register contents are queued at drive time and popped after the edge.
module tb_fixed_signed_arith_unit;

    localparam int W = 22;

    typedef struct packed {
        logic         v;
        logic [W-1:0] r;
        logic         o;
        logic         e;
        logic         g;
    } reg_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clk_en;
    logic         valid_in;
    logic [W-1:0] dataa;
    logic [W-1:0] datab;
    logic         add_sub;
    logic [W-1:0] cmpa;
    logic [W-1:0] cmpb;
    logic [W-1:0] result;
    logic         overflow;
    logic         aeb;
    logic         agb;
    logic [W-1:0] result_q;
    logic         overflow_q;
    logic         aeb_q;
    logic         agb_q;
    logic         valid_out;

    int errs   = 0;
    int checks = 0;

    reg_t sb[$];
    reg_t exp_reg;

    always #5 clk = ~clk;

    fixed_signed_arith_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .valid_in   (valid_in),
        .dataa      (dataa),
        .datab      (datab),
        .add_sub    (add_sub),
        .cmpa       (cmpa),
        .cmpb       (cmpb),
        .result     (result),
        .overflow   (overflow),
        .aeb        (aeb),
        .agb        (agb),
        .result_q   (result_q),
        .overflow_q (overflow_q),
        .aeb_q      (aeb_q),
        .agb_q      (agb_q),
        .valid_out  (valid_out)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic as, input logic [W-1:0] ca,
                         input logic [W-1:0] cb, output logic [W-1:0] r,
                         output logic o, output logic e, output logic g);
        longint sa, sb_, sca, scb, t;
        sa  = $signed(a);
        sb_ = $signed(b);
        sca = $signed(ca);
        scb = $signed(cb);
        t   = as ? sa + sb_ : sa - sb_;
        o   = (t > longint'((1 << (W - 1)) - 1)) || (t < -longint'(1 << (W - 1)));
        r   = t[W-1:0];
        e   = (sca == scb);
        g   = (sca > scb);
    endtask

    task automatic chk_comb(input string tag);
        logic [W-1:0] r;
        logic         o, e, g;
        model(dataa, datab, add_sub, cmpa, cmpb, r, o, e, g);
        chk({tag, ".result"}, 32'(result), 32'(r));
        chk({tag, ".ovf"}, 32'(overflow), 32'(o));
        chk({tag, ".aeb"}, 32'(aeb), 32'(e));
        chk({tag, ".agb"}, 32'(agb), 32'(g));
    endtask

    task automatic chk_regs(input string tag, input reg_t x);
        chk({tag, ".result_q"}, 32'(result_q), 32'(x.r));
        chk({tag, ".ovf_q"}, 32'(overflow_q), 32'(x.o));
        chk({tag, ".aeb_q"}, 32'(aeb_q), 32'(x.e));
        chk({tag, ".agb_q"}, 32'(agb_q), 32'(x.g));
        chk({tag, ".valid_out"}, 32'(valid_out), 32'(x.v));
    endtask

    task automatic pop_chk(input string tag);
        reg_t x;
        checks++;
        if (sb.size() == 0) begin
            errs++;
            $display("FAIL %s scoreboard empty got=%0d exp=1", tag, sb.size());
        end else begin
            x = sb.pop_front();
            chk_regs(tag, x);
        end
    endtask

    // Called at posedge+1; drives one operation and checks the edge after.
    task automatic step(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic as,
                        input logic [W-1:0] ca, input logic [W-1:0] cb,
                        input logic v, input logic en);
        logic [W-1:0] r;
        logic         o, e, g;
        dataa = a; datab = b; add_sub = as;
        cmpa = ca; cmpb = cb; valid_in = v; clk_en = en;
        #1;
        chk_comb(tag);
        model(a, b, as, ca, cb, r, o, e, g);
        if (en) exp_reg = '{v: v, r: r, o: o, e: e, g: g};
        sb.push_back(exp_reg);
        @(posedge clk);
        #1;
        pop_chk(tag);
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b0; valid_in = 1'b0;
        dataa = '0; datab = '0; add_sub = 1'b0; cmpa = '0; cmpb = '0;
        exp_reg = '0;
        #1;
        chk_regs("reset", exp_reg);
        @(posedge clk);
        #1;
        chk_regs("reset_edge", exp_reg);
        rst_n = 1'b1;

        step("add_1p0_0p5", 22'h100000, 22'h080000, 1'b1,
             22'h3FFFFF, 22'h000001, 1'b1, 1'b1);
        step("sub_neg", 22'h080000, 22'h100000, 1'b0,
             22'h000001, 22'h3FFFFF, 1'b0, 1'b1);
        step("add_ovf", 22'h1FFFFF, 22'h000001, 1'b1,
             22'h0C90FD, 22'h0C90FD, 1'b1, 1'b1);
        step("sub_ovf", 22'h200000, 22'h000001, 1'b0,
             22'h200000, 22'h000000, 1'b1, 1'b1);
        step("sub_min", 22'h000000, 22'h200000, 1'b0,
             22'h000000, 22'h200000, 1'b0, 1'b1);
        step("add_negneg", 22'h200000, 22'h200000, 1'b1,
             22'h1FFFFF, 22'h200000, 1'b1, 1'b1);

        step("load", 22'h100000, 22'h080000, 1'b1,
             22'h000005, 22'h000003, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            step("hold", 22'($urandom()), 22'($urandom()), 1'($urandom()),
                 22'($urandom()), 22'($urandom()), 1'b0, 1'b0);
        step("reen", 22'h0ABCDE, 22'h012345, 1'b0,
             22'h000007, 22'h000007, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++)
            step("rand", 22'($urandom()), 22'($urandom()), 1'($urandom()),
                 22'($urandom()), 22'($urandom()), 1'($urandom()),
                 1'($urandom_range(0, 3) != 0));

        step("preload", 22'h100000, 22'h080000, 1'b1,
             22'h000009, 22'h000002, 1'b1, 1'b1);
        dataa = 22'h033333; datab = 22'h011111; add_sub = 1'b1;
        cmpa = 22'h000001; cmpb = 22'h000002; valid_in = 1'b1; clk_en = 1'b1;
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_reg = '0;
        #1;
        chk_regs("async_rst", exp_reg);
        chk_comb("rst_comb");
        dataa = 22'h1FFFFF; datab = 22'h1FFFFF; cmpa = 22'h0C90FD; cmpb = 22'h0C90FD;
        #1;
        chk_comb("rst_comb2");
        @(posedge clk);
        #1;
        chk_regs("rst_hold", exp_reg);
        rst_n = 1'b1;
        step("post_rst", 22'h000010, 22'h000020, 1'b0,
             22'h000002, 22'h000001, 1'b1, 1'b1);

        checks++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
